// File: rtl/leitor_ataque.sv
// ---------------------------------------------------------------------------
// leitor_ataque
//   Attack-phase input reader for the battleship game. Synchronises and
//   debounces the confirm button, latches the shot coordinate from the
//   switches, checks the shot against the ship map, and keeps the hit/miss
//   bitmaps and the shot/hit counters shown on the LED matrix and 7-seg.
//
// Ports
//   clock        in   divided system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   enable       in   high while the game is in the attack phase
//   btn_confirm  in   confirm button, active-high, asynchronous
//   linha        in   [2:0] row to shoot (0..6 valid)
//   coluna       in   [2:0] column to shoot (0..4 valid)
//   mapa0..4     in   [6:0] ship map per column, bit r = row r
//   acerto0..4   out  [6:0] hit bitmap, same layout as mapa
//   erro0..4     out  [6:0] miss bitmap, same layout as mapa
//   tiros        out  [3:0] valid shots taken
//   acertos      out  [5:0] hits scored
//   evento       out  [1:0] one-cycle pulse: 00 none, 01 miss, 10 hit, 11 rejected
//   fim_jogo     out  high once the game is over
//   vitoria      out  high when the game ended with every ship cell hit
// ---------------------------------------------------------------------------
module leitor_ataque #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_SHOTS       = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       btn_confirm,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [6:0] acerto0,
  output logic [6:0] acerto1,
  output logic [6:0] acerto2,
  output logic [6:0] acerto3,
  output logic [6:0] acerto4,
  output logic [6:0] erro0,
  output logic [6:0] erro1,
  output logic [6:0] erro2,
  output logic [6:0] erro3,
  output logic [6:0] erro4,
  output logic [3:0] tiros,
  output logic [5:0] acertos,
  output logic [1:0] evento,
  output logic       fim_jogo,
  output logic       vitoria
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ESPERA   = 3'd1;
  localparam logic [2:0] S_DEBOUNCE = 3'd2;
  localparam logic [2:0] S_AVALIA   = 3'd3;
  localparam logic [2:0] S_SOLTA    = 3'd4;
  localparam logic [2:0] S_FIM      = 3'd5;

  localparam int                CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_MISS = 2'b01;
  localparam logic [1:0] EV_HIT  = 2'b10;
  localparam logic [1:0] EV_REJ  = 2'b11;

  // Number of ship cells on the map.
  function automatic logic [5:0] popcount35(input logic [34:0] v);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 35; i++) s = s + 6'(v[i]);
    return s;
  endfunction

  logic [2:0]       state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       lin_q, lin_d, col_q, col_d;
  logic [34:0]      acerto_q, acerto_d, erro_q, erro_d;
  logic [3:0]       tiros_q, tiros_d;
  logic [5:0]       acertos_q, acertos_d;
  logic [1:0]       evento_q, evento_d;
  logic             vitoria_q, vitoria_d;

  // Maps are handled as flat vectors: cell (r,c) lives at bit c*7+r.
  logic [34:0] mapa_flat;
  logic [5:0]  total;
  logic [5:0]  idx;
  logic        coord_ok;
  logic        win;

  assign mapa_flat = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign total     = popcount35(mapa_flat);
  assign idx       = 6'(col_q) * 6'd7 + 6'(lin_q);
  assign coord_ok  = (lin_q <= 3'd6) && (col_q <= 3'd4);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lin_d     = lin_q;
    col_d     = col_q;
    acerto_d  = acerto_q;
    erro_d    = erro_q;
    tiros_d   = tiros_q;
    acertos_d = acertos_q;
    evento_d  = EV_NONE;
    vitoria_d = vitoria_q;
    win       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_ESPERA;
      S_ESPERA: begin
        if (sync2_q) begin
          if (DB_MAX <= CNT_W'(1)) begin
            lin_d   = linha;
            col_d   = coluna;
            state_d = S_AVALIA;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!sync2_q) begin
          state_d = S_ESPERA;
        end else if (cnt_inc >= DB_MAX) begin
          lin_d   = linha;
          col_d   = coluna;
          state_d = S_AVALIA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_AVALIA: begin
        cnt_d   = '0;
        state_d = S_SOLTA;
        if (!coord_ok || acerto_q[idx] || erro_q[idx]) begin
          evento_d = EV_REJ;
        end else begin
          tiros_d = tiros_q + 4'd1;
          if (mapa_flat[idx]) begin
            acerto_d[idx] = 1'b1;
            acertos_d     = acertos_q + 6'd1;
            evento_d      = EV_HIT;
          end else begin
            erro_d[idx] = 1'b1;
            evento_d    = EV_MISS;
          end
          win = (acertos_d == total) && (total != 6'd0);
          if (win) vitoria_d = 1'b1;
          if (win || (tiros_d == 4'(MAX_SHOTS))) state_d = S_FIM;
        end
      end
      S_SOLTA: begin
        // Release needs an unbroken run of low samples; any high restarts it.
        if (sync2_q) begin
          cnt_d = '0;
        end else if (cnt_inc >= DB_MAX) begin
          state_d = S_ESPERA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FIM: state_d = S_FIM;
      default: state_d = S_IDLE;
    endcase

    // Leaving the attack phase wipes everything, including a partial debounce.
    if (!enable) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      acerto_d  = '0;
      erro_d    = '0;
      tiros_d   = '0;
      acertos_d = '0;
      evento_d  = EV_NONE;
      vitoria_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      acerto_q  <= '0;
      erro_q    <= '0;
      tiros_q   <= '0;
      acertos_q <= '0;
      evento_q  <= EV_NONE;
      vitoria_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= btn_confirm;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      acerto_q  <= acerto_d;
      erro_q    <= erro_d;
      tiros_q   <= tiros_d;
      acertos_q <= acertos_d;
      evento_q  <= evento_d;
      vitoria_q <= vitoria_d;
    end
  end

  // Latched coordinate is only consumed in AVALIA, so it needs no reset.
  always_ff @(posedge clock) begin
    lin_q <= lin_d;
    col_q <= col_d;
  end

  assign acerto0  = acerto_q[6:0];
  assign acerto1  = acerto_q[13:7];
  assign acerto2  = acerto_q[20:14];
  assign acerto3  = acerto_q[27:21];
  assign acerto4  = acerto_q[34:28];
  assign erro0    = erro_q[6:0];
  assign erro1    = erro_q[13:7];
  assign erro2    = erro_q[20:14];
  assign erro3    = erro_q[27:21];
  assign erro4    = erro_q[34:28];
  assign tiros    = tiros_q;
  assign acertos  = acertos_q;
  assign evento   = evento_q;
  assign fim_jogo = (state_q == S_FIM);
  assign vitoria  = vitoria_q;

endmodule

// File: tb/tb_leitor_ataque.sv
module tb_leitor_ataque;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       btn_confirm = 1'b0;
  logic [2:0] linha = '0, coluna = '0;
  logic [6:0] mapa0 = '0, mapa1 = '0, mapa2 = '0, mapa3 = '0, mapa4 = '0;
  logic [6:0] acerto0, acerto1, acerto2, acerto3, acerto4;
  logic [6:0] erro0, erro1, erro2, erro3, erro4;
  logic [3:0] tiros;
  logic [5:0] acertos;
  logic [1:0] evento;
  logic       fim_jogo, vitoria;

  leitor_ataque #(.DEBOUNCE_CYCLES(4), .MAX_SHOTS(15)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .btn_confirm(btn_confirm),
    .linha(linha), .coluna(coluna),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .acerto0(acerto0), .acerto1(acerto1), .acerto2(acerto2), .acerto3(acerto3), .acerto4(acerto4),
    .erro0(erro0), .erro1(erro1), .erro2(erro2), .erro3(erro3), .erro4(erro4),
    .tiros(tiros), .acertos(acertos), .evento(evento), .fim_jogo(fim_jogo), .vitoria(vitoria)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ev;
    logic [3:0]  t;
    logic [5:0]  a;
    logic [34:0] hit;
    logic [34:0] miss;
    logic        fim;
    logic        vit;
  } exp_t;
  exp_t sb[$];

  // Reference model of the game, indexed by cell number c*7+r.
  logic [34:0] m_map, m_hit, m_miss;
  int          m_t, m_a;
  logic        m_fim, m_vit;

  logic [34:0] dut_hit, dut_miss;
  assign dut_hit  = {acerto4, acerto3, acerto2, acerto1, acerto0};
  assign dut_miss = {erro4, erro3, erro2, erro1, erro0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_hit = '0; m_miss = '0; m_t = 0; m_a = 0; m_fim = 1'b0; m_vit = 1'b0;
  endtask

  function automatic int ships();
    int n = 0;
    for (int i = 0; i < 35; i++) n += int'(m_map[i]);
    return n;
  endfunction

  task automatic model_shot(input int r, input int c);
    exp_t e;
    int   i;
    if (m_fim) return;  // game over: the press must produce no event
    if (r > 6 || c > 4) begin
      e.ev = 2'b11;
    end else begin
      i = c * 7 + r;
      if (m_hit[i] || m_miss[i]) begin
        e.ev = 2'b11;
      end else begin
        m_t++;
        if (m_map[i]) begin m_hit[i] = 1'b1; m_a++; e.ev = 2'b10; end
        else begin m_miss[i] = 1'b1; e.ev = 2'b01; end
        if (m_a == ships() && ships() != 0) begin m_vit = 1'b1; m_fim = 1'b1; end
        else if (m_t == 15) m_fim = 1'b1;
      end
    end
    e.t = 4'(m_t); e.a = 6'(m_a); e.hit = m_hit; e.miss = m_miss;
    e.fim = m_fim; e.vit = m_vit;
    sb.push_back(e);
  endtask

  // Monitor: every non-zero evento must match the next expected shot result.
  always @(negedge clock) begin
    if (reset_n && evento !== 2'b00) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_evento: got %0b expected none", evento);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evento", 64'(evento), 64'(e.ev));
        chk("tiros", 64'(tiros), 64'(e.t));
        chk("acertos", 64'(acertos), 64'(e.a));
        chk("acerto_map", 64'(dut_hit), 64'(e.hit));
        chk("erro_map", 64'(dut_miss), 64'(e.miss));
        chk("fim_jogo", 64'(fim_jogo), 64'(e.fim));
        chk("vitoria", 64'(vitoria), 64'(e.vit));
      end
    end
  end

  task automatic press(input int r, input int c);
    model_shot(r, c);
    linha = 3'(r); coluna = 3'(c);
    btn_confirm = 1'b1;
    repeat (6) tick();
    btn_confirm = 1'b0;
    repeat (2) tick();
    linha = 3'($urandom); coluna = 3'($urandom);  // switch noise while releasing
    repeat (7) tick();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_acerto"}, 64'(dut_hit), 64'd0);
    chk({nm, "_erro"}, 64'(dut_miss), 64'd0);
    chk({nm, "_tiros"}, 64'(tiros), 64'd0);
    chk({nm, "_acertos"}, 64'(acertos), 64'd0);
    chk({nm, "_evento"}, 64'(evento), 64'd0);
    chk({nm, "_fim"}, 64'(fim_jogo), 64'd0);
    chk({nm, "_vit"}, 64'(vitoria), 64'd0);
  endtask

  task automatic new_game(input logic [34:0] map);
    enable = 1'b0;
    tick();
    check_all_zero("disable");
    m_map = map;
    {mapa4, mapa3, mapa2, mapa1, mapa0} = map;
    model_clear();
    enable = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] map;
    int          r, c, k;

    // Reset held for two edges with enable high.
    m_map = '0; model_clear();
    enable = 1'b1; reset_n = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    // Hit on (2,3), with a second ship so the game continues.
    map = '0; map[3*7+2] = 1'b1; map[0] = 1'b1;
    new_game(map);
    press(2, 3);
    chk("t2_acerto3", 64'(acerto3), 64'(7'b0000100));
    chk("t2_tiros", 64'(tiros), 64'd1);

    // Bouncy press: never four stable samples.
    linha = 3'd0; coluna = 3'd0;
    btn_confirm = 1'b1; repeat (2) tick();
    btn_confirm = 1'b0; tick();
    btn_confirm = 1'b1; repeat (2) tick();
    btn_confirm = 1'b0; repeat (10) tick();
    chk("t3_tiros", 64'(tiros), 64'd1);

    // Repeat coordinate, then out-of-range row.
    press(2, 3);
    press(7, 0);
    chk("t4_tiros", 64'(tiros), 64'd1);
    chk("t4_acertos", 64'(acertos), 64'd1);

    // Single-cell map: immediate win, then the button is ignored.
    map = '0; map[0] = 1'b1;
    new_game(map);
    press(0, 0);
    press(1, 1);
    chk("t5_fim", 64'(fim_jogo), 64'd1);
    chk("t5_vit", 64'(vitoria), 64'd1);

    // Empty map: 15 distinct misses end the game without victory.
    new_game('0);
    for (int i = 0; i < 15; i++) press(i % 7, i / 7);
    chk("t6_tiros", 64'(tiros), 64'd15);
    chk("t6_fim", 64'(fim_jogo), 64'd1);
    chk("t6_vit", 64'(vitoria), 64'd0);
    press(3, 3);
    chk("t6_tiros_hold", 64'(tiros), 64'd15);

    // Random games with sparse maps and a bias toward ship cells.
    for (int g = 0; g < 6; g++) begin
      map = '0;
      k = $urandom_range(0, 4);
      for (int s = 0; s < k; s++) map[$urandom_range(0, 34)] = 1'b1;
      new_game(map);
      for (int p = 0; p < 20; p++) begin
        if ($urandom_range(0, 1) == 1 && map != '0) begin
          do begin
            r = $urandom_range(0, 6); c = $urandom_range(0, 4);
          end while (map[c * 7 + r] == 1'b0);
        end else begin
          r = $urandom_range(0, 7); c = $urandom_range(0, 5);
        end
        press(r, c);
      end
      chk("rand_tiros", 64'(tiros), 64'(m_t));
      chk("rand_fim", 64'(fim_jogo), 64'(m_fim));
    end

    enable = 1'b0;
    tick();
    check_all_zero("final_disable");
    repeat (4) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
